// File: rtl/sec_countdown_timer.sv
// Settable 0-59 s BCD countdown timer with debounced start/load keys and active-low 7-seg digits.
// Outputs are registered one cycle behind state/value.
module sec_countdown_timer #(
    parameter int FREQ         = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       key_start_n,
    input  logic       key_load_n,
    input  logic [2:0] sw_tens,
    input  logic [3:0] sw_ones,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic       running,
    output logic       done
);

    localparam int PW = (FREQ > 1) ? $clog2(FREQ) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(FREQ - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [6:0]    SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // index 0 = start key, index 1 = load key
    logic [1:0]    key_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    key_acc;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    assign key_raw = {key_load_n, key_start_n};

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            key_acc   <= 2'b11;
            press     <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == key_acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    key_acc[i] <= sync2[i];
                    db_cnt[i]  <= '0;
                    press[i]   <= ~sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic start_p;
    logic load_p;
    assign start_p = press[0];
    assign load_p  = press[1];

    state_t        state, state_nxt;
    logic [2:0]    tens, tens_nxt, pre_tens, pre_tens_nxt;
    logic [3:0]    ones, ones_nxt, pre_ones, pre_ones_nxt;
    logic [PW-1:0] pre_cnt, pre_cnt_nxt;
    logic [2:0]    clamp_tens;
    logic [3:0]    clamp_ones;
    logic          tick, val_zero, val_one;

    assign clamp_tens = (sw_tens > 3'd5) ? 3'd5 : sw_tens;
    assign clamp_ones = (sw_ones > 4'd9) ? 4'd9 : sw_ones;
    assign tick       = (state == S_RUN) && (pre_cnt == PRE_MAX);
    assign val_zero   = (tens == 3'd0) && (ones == 4'd0);
    assign val_one    = (tens == 3'd0) && (ones == 4'd1);

    always_comb begin
        state_nxt    = state;
        tens_nxt     = tens;
        ones_nxt     = ones;
        pre_tens_nxt = pre_tens;
        pre_ones_nxt = pre_ones;
        pre_cnt_nxt  = pre_cnt;
        if (state == S_RUN) begin
            pre_cnt_nxt = tick ? '0 : pre_cnt + 1'b1;
        end
        if (load_p) begin
            state_nxt    = S_IDLE;
            tens_nxt     = clamp_tens;
            ones_nxt     = clamp_ones;
            pre_tens_nxt = clamp_tens;
            pre_ones_nxt = clamp_ones;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_p && !val_zero) begin
                        state_nxt   = S_RUN;
                        pre_cnt_nxt = '0;
                    end
                end
                S_RUN: begin
                    // a tick in the same cycle as a pause request is still applied
                    if (tick && !val_zero) begin
                        if (ones != 4'd0) begin
                            ones_nxt = ones - 4'd1;
                        end else begin
                            ones_nxt = 4'd9;
                            tens_nxt = tens - 3'd1;
                        end
                    end
                    if (tick && val_one) begin
                        state_nxt = S_DONE;
                    end else if (start_p) begin
                        state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_p) begin
                        state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start_p) begin
                        state_nxt = S_IDLE;
                        tens_nxt  = pre_tens;
                        ones_nxt  = pre_ones;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            tens     <= '0;
            ones     <= '0;
            pre_tens <= '0;
            pre_ones <= '0;
            pre_cnt  <= '0;
            HEX0     <= SEG_ZERO;
            HEX1     <= SEG_ZERO;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tens     <= tens_nxt;
            ones     <= ones_nxt;
            pre_tens <= pre_tens_nxt;
            pre_ones <= pre_ones_nxt;
            pre_cnt  <= pre_cnt_nxt;
            HEX0     <= seg7(ones);
            HEX1     <= seg7({1'b0, tens});
            running  <= (state == S_RUN);
            done     <= (state == S_DONE);
        end
    end

endmodule
